addsub_mul_sched: RTL and testbench

- Round-robin scheduler that shares one add/sub-then-multiply two-stage datapath between NREQ requesters.
- Each requester presents an operand set {a, b, c, s} over a valid/ready handshake.
- The block issues at most one operation per cycle into its internal pipeline: stage 1 is an 8-bit add/sub register, stage 2 is an 8x8 multiply.
- Results are buffered in a credit-protected result FIFO and returned in issue order, tagged with the originating requester ID.

---
 rtl/addsub_mul_sched.sv | 197 +++++++++++++++++++
 tb/tb_addsub_mul_sched.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_mul_sched.sv
`default_nettype none
// ============================================================================
// Module   : addsub_mul_sched
// Purpose  : Round-robin scheduler that shares one two-stage datapath
//            (8-bit add/sub register, then 8x8 unsigned multiply) between
//            NREQ requesters. Results are held in a credit-protected
//            first-word-fall-through FIFO. They are returned in issue order
//            and tagged with the ID of the requester that issued them.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            req_valid/req_ready - per-requester handshake (one-hot ready)
//            req_a/req_b/req_c   - packed 8-bit operands, requester i at [8i+:8]
//            req_s               - per-requester op select (1 = a+b, 0 = a-b)
//            res_valid/res_ready - result handshake
//            res_data, res_id    - FIFO head: 16-bit product and requester ID
//            busy                - stage 1 occupied or FIFO non-empty
//            stat_issued/stall   - optional saturating counters
// Options  : define ADDSUB_MUL_SCHED_STATS_EN to add the stat_* ports/counters
// Revision : 1.0 - initial release
// ============================================================================
module addsub_mul_sched #(
  parameter int NREQ       = 2,
  parameter int ID_W       = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [8*NREQ-1:0]   req_a,
  input  logic [8*NREQ-1:0]   req_b,
  input  logic [8*NREQ-1:0]   req_c,
  input  logic [NREQ-1:0]     req_s,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [15:0]         res_data,
  output logic [ID_W-1:0]     res_id,
  output logic                busy
`ifdef ADDSUB_MUL_SCHED_STATS_EN
  ,
  output logic [15:0]         stat_issued,
  output logic [15:0]         stat_stall
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  // Round-robin pointer and stage-1 pipeline register
  logic [ID_W-1:0]  r_rr_ptr;
  logic             r_v1;
  logic [7:0]       r_s1_sum;
  logic [7:0]       r_s1_c;
  logic [ID_W-1:0]  r_s1_id;

  // Result FIFO
  logic [15:0]      r_mem_data [FIFO_DEPTH];
  logic [ID_W-1:0]  r_mem_id   [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_found;
  logic [ID_W-1:0]  w_gnt;
  logic [CNT_W:0]   w_occ;
  logic             w_can_issue;
  logic             w_hs;
  logic [7:0]       w_a;
  logic [7:0]       w_b;
  logic [7:0]       w_c;
  logic [7:0]       w_sum;
  logic [15:0]      w_prod;
  logic             w_push;
  logic             w_pop;

  // --------------------------------------------------------------------------
  // Arbitration: scan from r_rr_ptr upward with wrap; the first valid wins.
  // --------------------------------------------------------------------------
  always_comb begin
    logic [ID_W:0] v_idx;
    w_found = 1'b0;
    w_gnt   = '0;
    for (int k = 0; k < NREQ; k++) begin
      v_idx = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
      if (v_idx >= (ID_W+1)'(NREQ)) begin
        v_idx = v_idx - (ID_W+1)'(NREQ);
      end
      if (!w_found && req_valid[v_idx[ID_W-1:0]]) begin
        w_found = 1'b1;
        w_gnt   = v_idx[ID_W-1:0];
      end
    end
  end

  // Credits: everything issued and not yet popped (stage 1 plus FIFO) must
  // fit in the FIFO. A pop in the same cycle does not return a credit, so
  // the FIFO can never overflow.
  assign w_occ       = {1'b0, r_count} + {{CNT_W{1'b0}}, r_v1};
  assign w_can_issue = (w_occ < (CNT_W+1)'(FIFO_DEPTH));
  assign w_hs        = w_found & w_can_issue & ~reset;

  always_comb begin
    req_ready = '0;
    if (w_hs) begin
      req_ready[w_gnt] = 1'b1;
    end
  end

  // Operand mux for the granted requester
  assign w_a   = req_a[{w_gnt, 3'b000} +: 8];
  assign w_b   = req_b[{w_gnt, 3'b000} +: 8];
  assign w_c   = req_c[{w_gnt, 3'b000} +: 8];
  assign w_sum = req_s[w_gnt] ? (w_a + w_b) : (w_a - w_b);

  // --------------------------------------------------------------------------
  // Pointer and stage-1 register (issue edge)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr <= '0;
      r_v1     <= 1'b0;
      r_s1_sum <= '0;
      r_s1_c   <= '0;
      r_s1_id  <= '0;
    end else begin
      r_v1 <= w_hs;
      if (w_hs) begin
        r_rr_ptr <= (w_gnt == ID_W'(NREQ-1)) ? '0 : (w_gnt + ID_W'(1));
        r_s1_sum <= w_sum;
        r_s1_c   <= w_c;
        r_s1_id  <= w_gnt;
      end
    end
  end

  // Stage 2: the full 16-bit product is written straight into the FIFO
  assign w_prod = {8'h00, r_s1_sum} * {8'h00, r_s1_c};
  assign w_push = r_v1;
  assign w_pop  = res_valid & res_ready;

  // FIFO storage carries no reset; the data path is gated by res_valid below
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= w_prod;
      r_mem_id[r_wr_ptr]   <= r_s1_id;
    end
  end

  // Power-of-two depth: pointers wrap naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign res_valid = (r_count != '0);
  assign res_data  = res_valid ? r_mem_data[r_rd_ptr] : 16'h0000;
  assign res_id    = res_valid ? r_mem_id[r_rd_ptr]   : '0;
  assign busy      = r_v1 | res_valid;

`ifdef ADDSUB_MUL_SCHED_STATS_EN
  logic [15:0] r_stat_issued;
  logic [15:0] r_stat_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_issued <= '0;
      r_stat_stall  <= '0;
    end else begin
      if (w_hs && (r_stat_issued != 16'hFFFF)) begin
        r_stat_issued <= r_stat_issued + 16'd1;
      end
      if ((|req_valid) && !w_hs && (r_stat_stall != 16'hFFFF)) begin
        r_stat_stall <= r_stat_stall + 16'd1;
      end
    end
  end

  assign stat_issued = r_stat_issued;
  assign stat_stall  = r_stat_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_addsub_mul_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_addsub_mul_sched
// Purpose  : Scoreboard bench for addsub_mul_sched. The reference model
//            tracks the requests that are outstanding and the round-robin
//            position. It predicts req_ready and queues the expected results.
//            A separate monitor pops the queue whenever the DUT presents a
//            result.
// Revision : 1.0 - initial release
// ============================================================================
module tb_addsub_mul_sched;
  localparam int NREQ  = 2;
  localparam int ID_W  = 1;
  localparam int DEPTH = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [8*NREQ-1:0]   req_a, req_b, req_c;
  logic [NREQ-1:0]     req_s;
  logic                res_valid;
  logic                res_ready;
  logic [15:0]         res_data;
  logic [ID_W-1:0]     res_id;
  logic                busy;
`ifdef ADDSUB_MUL_SCHED_STATS_EN
  logic [15:0]         stat_issued, stat_stall;
`endif

  addsub_mul_sched #(.NREQ(NREQ), .ID_W(ID_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_s(req_s),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id), .busy(busy)
`ifdef ADDSUB_MUL_SCHED_STATS_EN
    , .stat_issued(stat_issued), .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    int id;
    int avail;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  int   checks  = 0;
  int   passed  = 0;
  int   cyc     = 0;
  int   m_ptr   = 0;
  int   n_hs    = 0;
  bit   popped  = 0;
  bit   started = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: compares the FIFO head with the scoreboard and pops on acceptance
  always @(negedge clk) begin
    popped = 0;
    if (started) begin
      bit exp_v;
      exp_v = (sb.size() > 0) && (sb[0].avail <= cyc);
      check("res_valid", res_valid, exp_v);
      check("busy", busy, sb.size() > 0);
      if (exp_v && res_valid) begin
        check("res_data", res_data, sb[0].data);
        check("res_id", res_id, sb[0].id);
        if (res_ready) begin
          void'(sb.pop_front());
          popped = 1;
        end
      end
    end
  end

  // Reference model: the credits outstanding are the requests issued and not
  // yet popped. A pop in this cycle does not count as a free credit.
  always @(negedge clk) begin
    #2;
    if (started) begin
      if (reset) begin
        check("req_ready_in_reset", req_ready, 0);
        sb.delete();
        m_ptr = 0;
      end else begin
        int outstanding;
        int g;
        bit found;
        int exp_rdy;
        outstanding = sb.size() + int'(popped);
        found = 0;
        g = 0;
        for (int k = 0; k < NREQ; k++) begin
          int idx;
          idx = (m_ptr + k) % NREQ;
          if (!found && req_valid[idx]) begin
            found = 1;
            g = idx;
          end
        end
        exp_rdy = (found && outstanding < DEPTH) ? (1 << g) : 0;
        check("req_ready", req_ready, exp_rdy);
        if (exp_rdy != 0) begin
          int a, b, c, r;
          exp_t e;
          a = int'(req_a[8*g +: 8]);
          b = int'(req_b[8*g +: 8]);
          c = int'(req_c[8*g +: 8]);
          r = req_s[g] ? (a + b) % 256 : (a - b + 256) % 256;
          e.data  = r * c;
          e.id    = g;
          e.avail = cyc + 2;
          sb.push_back(e);
          grant_log.push_back(g);
          m_ptr = (g + 1) % NREQ;
          n_hs++;
        end
      end
    end
    cyc++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    req_a = NREQ*8'($urandom);
    for (int i = 0; i < NREQ; i++) begin
      req_a[8*i +: 8] = 8'($urandom);
      req_b[8*i +: 8] = 8'($urandom);
      req_c[8*i +: 8] = 8'($urandom);
    end
    req_s = NREQ'($urandom);
  endtask

  // Directed single operation with a fixed result, checked two cycles later
  task automatic issue_one(input int r, input int a, input int b, input int c,
                           input bit s, input int exp_data);
    bit got;
    req_valid = '0;
    req_valid[r] = 1'b1;
    req_a[8*r +: 8] = 8'(a);
    req_b[8*r +: 8] = 8'(b);
    req_c[8*r +: 8] = 8'(c);
    req_s[r] = s;
    got = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (req_ready[r]) begin
        got = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("issue_accept", got, 1);
    tick(1);
    req_valid = '0;
    tick(1);
    check("direct_valid", res_valid, 1);
    check("direct_data", res_data, exp_data);
    check("direct_id", res_id, r);
  endtask

  initial begin
    int n0;
    reset     = 1'b1;
    req_valid = '0;
    req_a = '0; req_b = '0; req_c = '0; req_s = '0;
    res_ready = 1'b1;
    tick(2);
    started = 1;
    reset   = 1'b0;
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_id", res_id, 0);
    check("rst_busy", busy, 0);

    // Add with wrap, then subtract with wrap
    issue_one(0, 200, 100, 3, 1'b1, 132);
    issue_one(1, 5, 10, 2, 1'b0, 502);
    tick(4);

    // Fairness after a fresh reset
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    grant_log.delete();
    req_valid = '1;
    for (int i = 0; i < 8; i++) begin
      rand_ops();
      tick(1);
    end
    req_valid = '0;
    tick(4);
    check("fair_count", grant_log.size(), 8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++) begin
      check("fair_order", grant_log[i], i % 2);
    end

    // Backpressure: exactly DEPTH issues, then stall with busy high
    res_ready = 1'b0;
    n0 = n_hs;
    req_valid = '1;
    rand_ops();
    tick(10);
    check("bp_issues", n_hs - n0, DEPTH);
    check("bp_ready_low", req_ready, 0);
    check("bp_busy", busy, 1);
    // Release: drain while the requesters stay valid (simultaneous push/pop)
    res_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rand_ops();
      tick(1);
    end
    req_valid = '0;
    tick(6);
    check("bp_drain_empty", sb.size(), 0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      req_valid = NREQ'($urandom);
      res_ready = ($urandom_range(0, 9) < 7);
      rand_ops();
      tick(1);
    end

    // Reset with operations in flight and queued
    res_ready = 1'b0;
    req_valid = '1;
    rand_ops();
    tick(3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    req_valid = '0;
    check("mid_rst_valid", res_valid, 0);
    check("mid_rst_data", res_data, 0);
    check("mid_rst_busy", busy, 0);
    res_ready = 1'b1;
    issue_one(1, 17, 3, 9, 1'b1, 180);

    tick(6);
    check("final_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Absolute time limit so the run cannot hang
  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
